// File: rtl/fsm_pkg.sv
// Shared definitions for the lab FSM set: direction encodings and the load clamp.
package fsm_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Saturate a load value into the legal range 0..n-1.
  function automatic int clamp_state(input int val, input int n);
    return (val >= n) ? n - 1 : val;
  endfunction

endpackage

// File: rtl/fsm_updown_moore.sv
// Up/down Moore sequencer over N states with terminal flags and a registered wrap strobe.
module fsm_updown_moore
  import fsm_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_dir,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] state,
  output logic         o_max,
  output logic         o_min,
  output logic         o_wrap
);

  localparam logic [W-1:0] TOP = W'(N - 1);

  logic [W-1:0] state_nxt;
  logic         wrap_nxt;
  logic         illegal;

  assign illegal = (int'(state) >= N);

  always_comb begin
    state_nxt = state;
    wrap_nxt  = 1'b0;
    casez ({i_load, i_en, i_dir})
      3'b1??: state_nxt = W'(clamp_state(int'(i_load_val), N));
      {2'b01, DIR_UP}: begin
        if (state == TOP) begin
          state_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          state_nxt = state + 1'b1;
        end
      end
      {2'b01, DIR_DN}: begin
        if (state == '0) begin
          state_nxt = TOP;
          wrap_nxt  = 1'b1;
        end else begin
          state_nxt = state - 1'b1;
        end
      end
      default: ;
    endcase
    // Out-of-range codes recover to 0 silently; only a load takes precedence.
    if (illegal && !i_load) begin
      state_nxt = '0;
      wrap_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= '0;
      o_wrap <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_wrap <= wrap_nxt;
    end
  end

  always_comb begin
    o_max = (state == TOP);
    o_min = (state == '0);
  end

endmodule

// File: tb/tb_fsm_updown_moore.sv
// Randomized + directed bench for fsm_updown_moore at N=4 and N=5 against an arithmetic model.
module tb_fsm_updown_moore;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, dir, load;
  logic [2:0] lv;

  logic [1:0] st4;
  logic [2:0] st5;
  logic       max4, min4, wrap4, max5, min5, wrap5;

  int total = 0;
  int bad   = 0;

  int m4 = 0, m5 = 0;
  bit w4 = 0, w5 = 0;

  always #5 clk = ~clk;

  fsm_updown_moore #(.N(4), .W(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_load(load),
    .i_load_val(lv[1:0]), .state(st4), .o_max(max4), .o_min(min4), .o_wrap(wrap4)
  );

  fsm_updown_moore #(.N(5), .W(3)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_dir(dir), .i_load(load),
    .i_load_val(lv), .state(st5), .o_max(max5), .o_min(min5), .o_wrap(wrap5)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference step: modular arithmetic over 0..n-1, wrap when the count crosses an end.
  task automatic mstep(input int n, input int s, input int lval, output int ns, output bit w);
    w = 0;
    if (load) ns = (lval >= n) ? n - 1 : lval;
    else if (s >= n) ns = 0;
    else if (en) begin
      ns = dir ? (s + 1) % n : (s + n - 1) % n;
      w  = dir ? (s == n - 1) : (s == 0);
    end else ns = s;
  endtask

  always @(posedge clk or negedge rst_n) begin
    int n4, n5;
    bit x4, x5;
    if (!rst_n) begin
      m4 = 0; w4 = 0; m5 = 0; w5 = 0;
    end else begin
      mstep(4, m4, int'(lv[1:0]), n4, x4);
      mstep(5, m5, int'(lv), n5, x5);
      m4 = n4; w4 = x4; m5 = n5; w5 = x5;
    end
  end

  always @(negedge clk) begin
    chk("st4",   int'(st4),   m4);
    chk("max4",  int'(max4),  int'(m4 == 3));
    chk("min4",  int'(min4),  int'(m4 == 0));
    chk("wrap4", int'(wrap4), int'(w4));
    chk("st5",   int'(st5),   m5);
    chk("max5",  int'(max5),  int'(m5 == 4));
    chk("min5",  int'(min5),  int'(m5 == 0));
    chk("wrap5", int'(wrap5), int'(w5));
  end

  task automatic cyc(input logic e, input logic d, input logic l, input logic [2:0] v);
    en = e; dir = d; load = l; lv = v;
    @(posedge clk);
    #1;
  endtask

  int up_st[5]   = '{1, 2, 3, 0, 1};
  int up_wr[5]   = '{0, 0, 0, 1, 0};
  int up_mx[5]   = '{0, 0, 1, 0, 0};
  int dn_st[5]   = '{3, 2, 1, 0, 3};
  int dn_wr[5]   = '{1, 0, 0, 0, 1};
  int dn_mx[5]   = '{1, 0, 0, 0, 1};
  int dn_mn[5]   = '{0, 0, 0, 1, 0};

  initial begin
    rst_n = 1'b0; en = 0; dir = 0; load = 0; lv = '0;
    #22;
    chk("rst_st4", int'(st4), 0);
    chk("rst_min4", int'(min4), 1);
    chk("rst_max4", int'(max4), 0);
    chk("rst_wrap4", int'(wrap4), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // async reset mid-count at state 2
    cyc(0, 0, 1, 3'd2);
    chk("ld2_st4", int'(st4), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_st4", int'(st4), 0);
    chk("arst_min4", int'(min4), 1);
    chk("arst_max4", int'(max4), 0);
    chk("arst_wrap4", int'(wrap4), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 3'd0);
      chk("up_st4", int'(st4), up_st[i]);
      chk("up_wrap4", int'(wrap4), up_wr[i]);
      chk("up_max4", int'(max4), up_mx[i]);
    end

    cyc(0, 0, 1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 3'd0);
      chk("dn_st4", int'(st4), dn_st[i]);
      chk("dn_wrap4", int'(wrap4), dn_wr[i]);
      chk("dn_max4", int'(max4), dn_mx[i]);
      chk("dn_min4", int'(min4), dn_mn[i]);
    end

    cyc(1, 1, 1, 3'd2);
    chk("ldpri_st4", int'(st4), 2);
    chk("ldpri_wrap4", int'(wrap4), 0);
    cyc(0, 0, 1, 3'd7);
    chk("clamp_st5", int'(st5), 4);
    chk("clamp_max5", int'(max5), 1);
    chk("clamp_st4", int'(st4), 3);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'($urandom_range(1)), 0, 3'd0);
      chk("hold_st4", int'(st4), 3);
      chk("hold_max4", int'(max4), 1);
    end
    cyc(1, 0, 0, 3'd0);
    chk("rev_st4", int'(st4), 2);
    chk("rev_wrap4", int'(wrap4), 0);
    cyc(0, 0, 1, 3'd0);
    cyc(1, 1, 0, 3'd0);
    chk("rev0_st4", int'(st4), 1);
    chk("rev0_wrap4", int'(wrap4), 0);

    // illegal-state recovery on the non-power-of-2 instance
    for (int k = 0; k < 2; k++) begin
      force dut5.state = 3'd6;
      m5 = 6;
      #1;
      chk("ill_max5", int'(max5), 0);
      chk("ill_min5", int'(min5), 0);
      release dut5.state;
      cyc(1'(k == 0), 1'(k == 0), 0, 3'd0);
      chk("ill_st5", int'(st5), 0);
      chk("ill_wrap5", int'(wrap5), 0);
    end

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
          1'($urandom_range(7) == 0), 3'($urandom_range(7)));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
